// File: rtl/timer_counter_pkg.sv
// ============================================================================
// timer_counter_pkg : shared register offsets, CTRL fields, MODE codes, states
// Revision: 1.0
// ============================================================================
`default_nettype none

package timer_counter_pkg;

  // Register word offsets, decoded from addr[3:2]
  localparam logic [1:0] C_OFF_CTRL     = 2'd0;
  localparam logic [1:0] C_OFF_PRESET   = 2'd1;
  localparam logic [1:0] C_OFF_COUNT    = 2'd2;
  localparam logic [1:0] C_OFF_PRESCALE = 2'd3;

  localparam int C_CTRL_EN      = 0;
  localparam int C_CTRL_MODE_LO = 1;
  localparam int C_CTRL_MODE_HI = 2;
  localparam int C_CTRL_IM      = 3;

  localparam logic [1:0] C_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] C_MODE_RELOAD  = 2'b01;

  localparam int C_PRESCALE_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
// ============================================================================
// timer_prescaler : divider that emits one tick every prescale+1 run cycles
// Revision: 1.0
// ============================================================================
`default_nettype none

module timer_prescaler
  import timer_counter_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    run,
  input  logic [C_PRESCALE_W-1:0] prescale,
  output logic                    tick
);

  logic [C_PRESCALE_W-1:0] r_div;

  assign tick = (r_div == prescale);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (clear) begin
      r_div <= '0;
    end else if (run) begin
      r_div <= tick ? '0 : r_div + C_PRESCALE_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_counter.sv
// ============================================================================
// timer_counter : memory-mapped down-counting timer with one-shot/auto-reload
// Optional PRESCALE register at 0xC enabled by TIMER_PRESCALE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int               CNT_W      = 32,
  parameter logic [CNT_W-1:0] RST_PRESET = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [CNT_W-1:0]   r_preset;
  logic               r_flag, w_flag_nxt;
  logic               r_en, w_en_nxt;
  logic [1:0]         r_mode;
  logic               r_im, w_im_nxt;
  logic               r_irq;
  logic               w_wr, w_wr_ctrl, w_wr_preset;
  logic               w_one_shot;
  logic               w_tick;
  logic               w_unused_bits;

  assign w_wr        = we && (byteen == 4'b1111);
  assign w_wr_ctrl   = w_wr && (addr[3:2] == C_OFF_CTRL);
  assign w_wr_preset = w_wr && (addr[3:2] == C_OFF_PRESET);
  assign w_one_shot  = (r_mode != C_MODE_RELOAD);
  assign w_im_nxt    = w_wr_ctrl ? wdata[C_CTRL_IM] : r_im;
  assign w_unused_bits = ^{addr[31:4], addr[1:0], wdata};

`ifdef TIMER_PRESCALE_EN
  logic [C_PRESCALE_W-1:0] r_prescale;
  logic                    w_wr_prescale;

  assign w_wr_prescale = w_wr && (addr[3:2] == C_OFF_PRESCALE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prescale <= '0;
    end else if (w_wr_prescale) begin
      r_prescale <= wdata[C_PRESCALE_W-1:0];
    end
  end

  timer_prescaler u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clear    ((r_state == ST_LOAD) || !r_en),
    .run      (r_state == ST_CNT),
    .prescale (r_prescale),
    .tick     (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_preset <= RST_PRESET;
      r_flag   <= 1'b0;
      r_en     <= 1'b0;
      r_mode   <= C_MODE_ONESHOT;
      r_im     <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_flag  <= w_flag_nxt;
      r_en    <= w_en_nxt;
      r_im    <= w_im_nxt;
      r_irq   <= w_flag_nxt & w_im_nxt;
      if (w_wr_ctrl) begin
        r_mode <= wdata[C_CTRL_MODE_HI:C_CTRL_MODE_LO];
      end
      if (w_wr_preset) begin
        r_preset <= wdata[CNT_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_flag_nxt  = r_flag;
    w_en_nxt    = r_en;
    case (r_state)
      ST_IDLE: begin
        if (r_en) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!r_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_tick) begin
          // PRESET of 0 falls through here exactly like PRESET of 1
          if (r_count > CNT_W'(1)) begin
            w_count_nxt = r_count - CNT_W'(1);
          end else begin
            w_count_nxt = '0;
            w_flag_nxt  = 1'b1;
            w_state_nxt = ST_INT;
          end
        end
      end
      ST_INT: begin
        w_state_nxt = ST_IDLE;
        if (w_one_shot) w_en_nxt = 1'b0;
        else            w_flag_nxt = 1'b0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Bus writes take priority over the FSM on the registers they touch
    if (w_wr_ctrl) w_en_nxt = wdata[C_CTRL_EN];
    if ((w_wr_ctrl || w_wr_preset) && w_one_shot) w_flag_nxt = 1'b0;
  end

  always_comb begin
    rdata = '0;
    case (addr[3:2])
      C_OFF_CTRL:   rdata = {28'd0, r_im, r_mode, r_en};
      C_OFF_PRESET: rdata = 32'(r_preset);
      C_OFF_COUNT:  rdata = 32'(r_count);
`ifdef TIMER_PRESCALE_EN
      C_OFF_PRESCALE: rdata = 32'(r_prescale);
`endif
      default:      rdata = '0;
    endcase
  end

  assign irq = r_irq;

endmodule

`default_nettype wire

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped down-counting timer on the CPU's data bus, behind the address bridge.
- Its interrupt output drives one bit of the CPU's hwInt[5:0]. It is the device that produces the external interrupts the CP0 unit responds to.
- It has three software-visible registers: CTRL, PRESET and COUNT. Two count modes: one-shot (latched interrupt) and auto-reload (single-cycle pulse).

Parameters:
CNT_W, 32, counter/preset width in bits (2..32); registers are zero-extended to 32 bits on read.
RST_PRESET, 0, reset value of PRESET.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset. Asserting it low clears all state immediately; deassertion is synchronous to clk by the system.
addr  input  32  byte address from CPU data bus; only addr[3:2] is decoded (0x0 CTRL, 0x4 PRESET, 0x8 COUNT, 0xC PRESCALE/reserved).
we  input  1  write strobe, already gated by bridge address decode.
byteen  input  4  byte enables; a write takes effect only when byteen == 4'b1111.
wdata  input  32  write data.
rdata  output  32  combinational read of the register selected by addr[3:2].
irq  output  1  interrupt request to CPU hwInt bit.

Behaviour:
- CTRL fields: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (interrupt mask). Bits [31:4] read 0 and ignore writes.
- COUNT is read-only; writes to 0x8 are ignored.
- Reset values: CTRL=0, PRESET=RST_PRESET, COUNT=0, state=IDLE, irq flag=0, irq=0. rdata follows the reset register values.
- FSM states:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT: if !EN, go to IDLE (COUNT holds its value). Otherwise, if COUNT>1, COUNT<=COUNT-1. Otherwise COUNT<=0, irq flag<=1, go to INT.
  - INT:
    - MODE 00: CTRL.EN<=0, go to IDLE; irq flag stays set.
    - MODE 01: go to IDLE; irq flag<=0 (flag is high for exactly 1 cycle). Because EN stays 1, the next pass goes IDLE->LOAD->CNT, i.e. auto-reload.
- irq = flag & CTRL.IM, registered (no combinational path from bus).
- Timing: PRESET=N (N>=1) gives the flag asserted N+2 cycles after the EN write edge (1 cycle IDLE, 1 cycle LOAD, N cycles CNT). PRESET=0 behaves as PRESET=1.
- Mode 01 period is N+3 cycles (adds INT).
- In one-shot mode, a write to CTRL or PRESET clears the irq flag.
- Simultaneous bus write and FSM update: the bus write wins on the written register, e.g. a CTRL write during INT keeps the written EN. The FSM state transition still occurs.
- A PRESET write during CNT does not affect the running COUNT; the new value is used at the next LOAD.
- A write with partial byteen, or to a reserved offset, is a no-op.
- Reset asserted mid-count: immediate return to reset values; irq drops asynchronously.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined: offset 0xC is a read/write 16-bit PRESCALE register (reset 0, upper bits read 0). In CNT, the decrement/terminal check happens only on cycles where an internal divider reaches PRESCALE, giving 1 tick per PRESCALE+1 cycles. The divider clears on LOAD and on !EN.
- Undefined: 0xC reads 0, writes are ignored, and every CNT cycle ticks.

Decomposition:
- Shared header (def.v-style constants): register offsets, CTRL bit positions, MODE codes, FSM state encodings (IDLE/LOAD/CNT/INT).
- One natural sub-module, timer_prescaler (divider counter plus tick output), instantiated only under TIMER_PRESCALE_EN.
- Everything else lives in timer_counter.

Test Plan:
1. Reset low mid-count with COUNT=7 -> rdata at 0x8 reads 0 and irq=0 the same cycle; after release, CTRL reads 0 and PRESET reads RST_PRESET.
2. Write PRESET=5, then CTRL=0x9 (EN, one-shot, IM) -> COUNT sequence 5,4,3,2,1,0; irq rises 7 cycles after the CTRL write edge and stays high; CTRL reads 0x8. Then write CTRL=0x8 -> irq falls next cycle.
3. PRESET=3, CTRL=0xB (auto-reload, IM) -> irq is a 1-cycle pulse every 6 cycles, COUNT reloads 3 each period. Write CTRL=0x2 -> counting stops, COUNT holds its value.
4. PRESET=4, CTRL=0x1 (IM=0) -> flag sets but irq stays 0. Then write CTRL=0x9 while in IDLE with the flag set -> flag cleared by the CTRL write, so irq stays 0; the counter restarts.
5. Write COUNT=0x55, write PRESET with byteen=4'b0011, write 0xC with the macro off -> all ignored; register reads are unchanged, 0xC reads 0.
6. Macro on, PRESCALE=2, PRESET=2 -> COUNT decrements every 3 cycles; irq asserts at the expected prescaled cycle (LOAD+6).
